// File: rtl/wb_trap_unit.sv
// wb_trap_unit: writeback trap generator and machine-mode trap CSR file.
// Define TRAP_TIMER_IRQ_EN to enable the machine-timer interrupt path (mie.MTIE, mip.MTIP).
module wb_trap_unit #(
  parameter int PC_WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wb_valid_i,
  input  logic [PC_WIDTH-1:0] wb_pc_i,
  input  logic                wb_exc_i,
  input  logic [3:0]          wb_exc_cause_i,
  input  logic [31:0]         wb_exc_tval_i,
  input  logic                wb_mret_i,
  input  logic                csr_we_i,
  input  logic [11:0]         csr_addr_i,
  input  logic [31:0]         csr_wdata_i,
  output logic [31:0]         csr_rdata_o,
  input  logic                irq_timer_i,
  output logic                wb_commit_o,
  output logic                wb_trap_o,
  output logic [PC_WIDTH-1:0] wb_trap_handle_pc_o
);
  typedef enum logic {RUN, DRAIN} state_t;
  state_t r_state;
  logic r_mie, r_mpie;
  logic [PC_WIDTH-1:0] r_mtvec, r_mepc;
  logic [31:0] r_mcause, r_mtval;
  logic w_act, w_irq, w_exc, w_int, w_mret, w_vec, w_csr_we;
  logic [31:0] w_mie_rd, w_mip_rd;
  logic [PC_WIDTH-1:0] w_wd;
  assign w_act    = wb_valid_i & (r_state == RUN);
  assign w_exc    = w_act & wb_exc_i;
  assign w_int    = w_act & ~wb_exc_i & w_irq;
  assign w_mret   = w_act & ~wb_exc_i & ~w_irq & wb_mret_i;
  assign w_vec    = w_exc | w_int;
  assign w_csr_we = w_act & csr_we_i & ~wb_trap_o;
  assign w_wd     = PC_WIDTH'(csr_wdata_i);
  assign wb_trap_o           = w_vec | w_mret;
  assign wb_commit_o         = w_act & ~w_vec;
  assign wb_trap_handle_pc_o = w_vec ? {r_mtvec[PC_WIDTH-1:2], 2'b00} : w_mret ? r_mepc : '0;
`ifdef TRAP_TIMER_IRQ_EN
  logic r_mtie, r_mtip;
  assign w_irq    = r_mie & r_mtie & r_mtip;
  assign w_mie_rd = {24'b0, r_mtie, 7'b0};
  assign w_mip_rd = {24'b0, r_mtip, 7'b0};
  always_ff @(posedge clk)
    if (rst) begin
      r_mtie <= 1'b0;
      r_mtip <= 1'b0;
    end else begin
      r_mtip <= irq_timer_i;
      if (w_csr_we && csr_addr_i == 12'h304) r_mtie <= csr_wdata_i[7];
    end
`else
  logic w_unused;
  assign w_unused = irq_timer_i;
  assign w_irq    = 1'b0;
  assign w_mie_rd = '0;
  assign w_mip_rd = '0;
`endif
  assign csr_rdata_o = csr_addr_i == 12'h300 ? {24'b0, r_mpie, 3'b0, r_mie, 3'b0} :
                       csr_addr_i == 12'h304 ? w_mie_rd :
                       csr_addr_i == 12'h305 ? 32'(r_mtvec) :
                       csr_addr_i == 12'h341 ? 32'(r_mepc) :
                       csr_addr_i == 12'h342 ? r_mcause :
                       csr_addr_i == 12'h343 ? r_mtval :
                       csr_addr_i == 12'h344 ? w_mip_rd : 32'h0;
  always_ff @(posedge clk)
    if (rst) begin
      r_state  <= RUN;
      r_mie    <= 1'b0;
      r_mpie   <= 1'b0;
      r_mtvec  <= '0;
      r_mepc   <= '0;
      r_mcause <= '0;
      r_mtval  <= '0;
    end else begin
      r_state <= wb_trap_o ? DRAIN : RUN;
      if (w_vec) begin
        r_mepc   <= wb_pc_i;
        r_mcause <= w_int ? 32'h8000_0007 : {28'b0, wb_exc_cause_i};
        r_mtval  <= w_int ? 32'h0 : wb_exc_tval_i;
        r_mpie   <= r_mie;
        r_mie    <= 1'b0;
      end else if (w_mret) begin
        r_mie  <= r_mpie;
        r_mpie <= 1'b1;
      end else if (w_csr_we) begin
        case (csr_addr_i)
          12'h300: begin
            r_mie  <= csr_wdata_i[3];
            r_mpie <= csr_wdata_i[7];
          end
          12'h305: r_mtvec  <= w_wd;
          12'h341: r_mepc   <= {w_wd[PC_WIDTH-1:2], 2'b00};
          12'h342: r_mcause <= csr_wdata_i;
          12'h343: r_mtval  <= csr_wdata_i;
          default: ;
        endcase
      end
    end
endmodule

// File: tb/tb_wb_trap_unit.sv
// tb_wb_trap_unit: directed scenarios plus randomized run against a CSR-map reference model.
module tb_wb_trap_unit;
  logic clk = 1'b0, rst = 1'b1;
  logic wb_valid_i, wb_exc_i, wb_mret_i, csr_we_i, irq_timer_i;
  logic [31:0] wb_pc_i, wb_exc_tval_i, csr_wdata_i, csr_rdata_o, wb_trap_handle_pc_o;
  logic [3:0] wb_exc_cause_i;
  logic [11:0] csr_addr_i;
  logic wb_commit_o, wb_trap_o;
  int n_chk = 0, n_fail = 0;
  logic [31:0] rd;
`ifdef TRAP_TIMER_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  wb_trap_unit #(.PC_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .wb_valid_i(wb_valid_i), .wb_pc_i(wb_pc_i), .wb_exc_i(wb_exc_i),
    .wb_exc_cause_i(wb_exc_cause_i), .wb_exc_tval_i(wb_exc_tval_i), .wb_mret_i(wb_mret_i),
    .csr_we_i(csr_we_i), .csr_addr_i(csr_addr_i), .csr_wdata_i(csr_wdata_i),
    .csr_rdata_o(csr_rdata_o), .irq_timer_i(irq_timer_i), .wb_commit_o(wb_commit_o),
    .wb_trap_o(wb_trap_o), .wb_trap_handle_pc_o(wb_trap_handle_pc_o)
  );

  always #5 clk = ~clk;

  // Reference model: CSRs as words in an address-keyed map with per-CSR write masks.
  logic [31:0] m_csr [logic [11:0]];
  logic [31:0] m_wmask [logic [11:0]];
  logic m_drain, m_mtip;

  function automatic logic [31:0] m_read(input logic [11:0] a);
    if (a == 12'h344) return IRQ_EN ? {24'b0, m_mtip, 7'b0} : 32'h0;
    return m_csr.exists(a) ? m_csr[a] : 32'h0;
  endfunction

  task automatic m_reset();
    m_wmask.delete();
    m_csr.delete();
    m_wmask[12'h300] = 32'h88;
    m_wmask[12'h305] = 32'hFFFF_FFFF;
    m_wmask[12'h341] = 32'hFFFF_FFFC;
    m_wmask[12'h342] = 32'hFFFF_FFFF;
    m_wmask[12'h343] = 32'hFFFF_FFFF;
    if (IRQ_EN) m_wmask[12'h304] = 32'h80;
    foreach (m_wmask[a]) m_csr[a] = 32'h0;
    m_drain = 1'b0;
    m_mtip = 1'b0;
  endtask

  task automatic idle();
    wb_valid_i = 0; wb_exc_i = 0; wb_mret_i = 0; csr_we_i = 0;
    wb_pc_i = 0; wb_exc_cause_i = 0; wb_exc_tval_i = 0; csr_addr_i = 0; csr_wdata_i = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    irq_timer_i = 0;
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  task automatic csr_wr(input logic [11:0] a, input logic [31:0] d);
    idle();
    wb_valid_i = 1; wb_pc_i = 32'h1000; csr_we_i = 1; csr_addr_i = a; csr_wdata_i = d;
    tick();
    idle();
  endtask

  task automatic csr_rd(input logic [11:0] a, output logic [31:0] d);
    idle();
    csr_addr_i = a;
    #1;
    d = csr_rdata_o;
  endtask

  task automatic drive_exc(input logic [31:0] pc, input logic [3:0] cause, input logic [31:0] tval);
    idle();
    wb_valid_i = 1; wb_exc_i = 1; wb_pc_i = pc; wb_exc_cause_i = cause; wb_exc_tval_i = tval;
  endtask

  task automatic test_reset();
    logic [11:0] addrs [8] = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342, 12'h343, 12'h344, 12'h7C0};
    do_reset();
    #1;
    n_chk++; if (wb_trap_o !== 1'b0) begin n_fail++; $display("FAIL reset_trap got %h want 0", wb_trap_o); end
    n_chk++; if (wb_commit_o !== 1'b0) begin n_fail++; $display("FAIL reset_commit got %h want 0", wb_commit_o); end
    n_chk++; if (wb_trap_handle_pc_o !== 32'h0) begin n_fail++; $display("FAIL reset_pc got %h want 0", wb_trap_handle_pc_o); end
    foreach (addrs[i]) begin
      csr_rd(addrs[i], rd);
      n_chk++; if (rd !== 32'h0) begin n_fail++; $display("FAIL reset_csr_%h got %h want 0", addrs[i], rd); end
    end
  endtask

  task automatic test_exception();
    do_reset();
    csr_wr(12'h305, 32'h100);
    drive_exc(32'h80, 4'd2, 32'hDEAD);
    csr_we_i = 1; csr_addr_i = 12'h343; csr_wdata_i = 32'h1234;
    #1;
    n_chk++; if (wb_trap_o !== 1'b1) begin n_fail++; $display("FAIL exc_trap got %h want 1", wb_trap_o); end
    n_chk++; if (wb_trap_handle_pc_o !== 32'h100) begin n_fail++; $display("FAIL exc_target got %h want 100", wb_trap_handle_pc_o); end
    n_chk++; if (wb_commit_o !== 1'b0) begin n_fail++; $display("FAIL exc_commit got %h want 0", wb_commit_o); end
    tick();
    csr_rd(12'h341, rd);
    n_chk++; if (rd !== 32'h80) begin n_fail++; $display("FAIL exc_mepc got %h want 80", rd); end
    csr_rd(12'h342, rd);
    n_chk++; if (rd !== 32'h2) begin n_fail++; $display("FAIL exc_mcause got %h want 2", rd); end
    csr_rd(12'h343, rd);
    n_chk++; if (rd !== 32'hDEAD) begin n_fail++; $display("FAIL exc_mtval got %h want dead", rd); end
    csr_rd(12'h300, rd);
    n_chk++; if (rd !== 32'h0) begin n_fail++; $display("FAIL exc_mstatus got %h want 0", rd); end
    tick();
  endtask

  task automatic test_mret();
    csr_wr(12'h300, 32'h8);
    drive_exc(32'h80, 4'd3, 32'h0);
    tick();
    csr_rd(12'h300, rd);
    n_chk++; if (rd !== 32'h80) begin n_fail++; $display("FAIL mret_pre_mstatus got %h want 80", rd); end
    tick();
    idle();
    wb_valid_i = 1; wb_mret_i = 1; wb_pc_i = 32'h104;
    #1;
    n_chk++; if (wb_trap_o !== 1'b1) begin n_fail++; $display("FAIL mret_trap got %h want 1", wb_trap_o); end
    n_chk++; if (wb_trap_handle_pc_o !== 32'h80) begin n_fail++; $display("FAIL mret_target got %h want 80", wb_trap_handle_pc_o); end
    n_chk++; if (wb_commit_o !== 1'b1) begin n_fail++; $display("FAIL mret_commit got %h want 1", wb_commit_o); end
    tick();
    csr_rd(12'h300, rd);
    n_chk++; if (rd !== 32'h88) begin n_fail++; $display("FAIL mret_mstatus got %h want 88", rd); end
    tick();
  endtask

  task automatic test_drain();
    drive_exc(32'h40, 4'd1, 32'h11);
    tick();
    drive_exc(32'h44, 4'd4, 32'h22);
    csr_we_i = 1; csr_addr_i = 12'h343; csr_wdata_i = 32'h55;
    #1;
    n_chk++; if (wb_trap_o !== 1'b0) begin n_fail++; $display("FAIL drain_trap got %h want 0", wb_trap_o); end
    n_chk++; if (wb_commit_o !== 1'b0) begin n_fail++; $display("FAIL drain_commit got %h want 0", wb_commit_o); end
    n_chk++; if (wb_trap_handle_pc_o !== 32'h0) begin n_fail++; $display("FAIL drain_pc got %h want 0", wb_trap_handle_pc_o); end
    tick();
    csr_rd(12'h343, rd);
    n_chk++; if (rd !== 32'h11) begin n_fail++; $display("FAIL drain_mtval got %h want 11", rd); end
    idle();
    wb_valid_i = 1; wb_pc_i = 32'h48; csr_we_i = 1; csr_addr_i = 12'h343; csr_wdata_i = 32'h55;
    #1;
    n_chk++; if (wb_commit_o !== 1'b1 || wb_trap_o !== 1'b0) begin n_fail++; $display("FAIL post_drain_retire got commit=%h trap=%h want 1/0", wb_commit_o, wb_trap_o); end
    tick();
    csr_rd(12'h343, rd);
    n_chk++; if (rd !== 32'h55) begin n_fail++; $display("FAIL post_drain_mtval got %h want 55", rd); end
  endtask

  task automatic test_interrupt();
    do_reset();
    csr_wr(12'h305, 32'h100);
    csr_wr(12'h300, 32'h8);
    csr_wr(12'h304, 32'h80);
    irq_timer_i = 1;
    tick();
`ifdef TRAP_TIMER_IRQ_EN
    csr_rd(12'h344, rd);
    n_chk++; if (rd !== 32'h80) begin n_fail++; $display("FAIL irq_mip got %h want 80", rd); end
    idle();
    wb_valid_i = 1; wb_pc_i = 32'h200; csr_we_i = 1; csr_addr_i = 12'h305; csr_wdata_i = 32'h777;
    #1;
    n_chk++; if (wb_trap_o !== 1'b1) begin n_fail++; $display("FAIL irq_trap got %h want 1", wb_trap_o); end
    n_chk++; if (wb_trap_handle_pc_o !== 32'h100) begin n_fail++; $display("FAIL irq_target got %h want 100", wb_trap_handle_pc_o); end
    n_chk++; if (wb_commit_o !== 1'b0) begin n_fail++; $display("FAIL irq_commit got %h want 0", wb_commit_o); end
    tick();
    csr_rd(12'h341, rd);
    n_chk++; if (rd !== 32'h200) begin n_fail++; $display("FAIL irq_mepc got %h want 200", rd); end
    csr_rd(12'h342, rd);
    n_chk++; if (rd !== 32'h8000_0007) begin n_fail++; $display("FAIL irq_mcause got %h want 80000007", rd); end
    csr_rd(12'h305, rd);
    n_chk++; if (rd !== 32'h100) begin n_fail++; $display("FAIL irq_write_suppressed got %h want 100", rd); end
    tick();
    csr_wr(12'h300, 32'h8);
`else
    csr_rd(12'h304, rd);
    n_chk++; if (rd !== 32'h0) begin n_fail++; $display("FAIL noirq_mie got %h want 0", rd); end
    csr_rd(12'h344, rd);
    n_chk++; if (rd !== 32'h0) begin n_fail++; $display("FAIL noirq_mip got %h want 0", rd); end
    idle();
    wb_valid_i = 1; wb_pc_i = 32'h200;
    #1;
    n_chk++; if (wb_trap_o !== 1'b0 || wb_commit_o !== 1'b1) begin n_fail++; $display("FAIL noirq_retire got trap=%h commit=%h want 0/1", wb_trap_o, wb_commit_o); end
    tick();
    idle();
`endif
    drive_exc(32'h300, 4'd5, 32'h9);
    #1;
    n_chk++; if (wb_trap_o !== 1'b1 || wb_trap_handle_pc_o !== 32'h100) begin n_fail++; $display("FAIL prio_trap got trap=%h pc=%h want 1/100", wb_trap_o, wb_trap_handle_pc_o); end
    tick();
    csr_rd(12'h342, rd);
    n_chk++; if (rd !== 32'h5) begin n_fail++; $display("FAIL prio_mcause got %h want 5", rd); end
    csr_rd(12'h343, rd);
    n_chk++; if (rd !== 32'h9) begin n_fail++; $display("FAIL prio_mtval got %h want 9", rd); end
    irq_timer_i = 0;
    tick();
  endtask

  task automatic test_csr_map();
    do_reset();
    csr_wr(12'h341, 32'hFFFF_FFFF);
    csr_rd(12'h341, rd);
    n_chk++; if (rd !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL mepc_align got %h want fffffffc", rd); end
    csr_wr(12'h7C0, 32'h1234);
    csr_rd(12'h7C0, rd);
    n_chk++; if (rd !== 32'h0) begin n_fail++; $display("FAIL unmapped_read got %h want 0", rd); end
    csr_rd(12'h341, rd);
    n_chk++; if (rd !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL unmapped_side got %h want fffffffc", rd); end
    csr_wr(12'h300, 32'hFFFF_FFFF);
    csr_rd(12'h300, rd);
    n_chk++; if (rd !== 32'h88) begin n_fail++; $display("FAIL mstatus_mask got %h want 88", rd); end
    csr_wr(12'h344, 32'hFFFF_FFFF);
    csr_rd(12'h344, rd);
    n_chk++; if (rd !== 32'h0) begin n_fail++; $display("FAIL mip_ro got %h want 0", rd); end
  endtask

  task automatic test_reset_in_drain();
    logic [11:0] addrs [6] = '{12'h300, 12'h305, 12'h341, 12'h342, 12'h343, 12'h304};
    csr_wr(12'h305, 32'h100);
    drive_exc(32'h60, 4'd7, 32'h77);
    tick();
    wb_valid_i = 1; csr_we_i = 1; csr_addr_i = 12'h305; csr_wdata_i = 32'h200;
    rst = 1;
    tick();
    rst = 0;
    foreach (addrs[i]) begin
      csr_rd(addrs[i], rd);
      n_chk++; if (rd !== 32'h0) begin n_fail++; $display("FAIL rst_drain_csr_%h got %h want 0", addrs[i], rd); end
    end
    drive_exc(32'h64, 4'd1, 32'h0);
    #1;
    n_chk++; if (wb_trap_o !== 1'b1 || wb_trap_handle_pc_o !== 32'h0) begin n_fail++; $display("FAIL rst_drain_run got trap=%h pc=%h want 1/0", wb_trap_o, wb_trap_handle_pc_o); end
    tick();
    idle();
    tick();
  endtask

  task automatic test_random();
    logic [11:0] addrs [8] = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342, 12'h343, 12'h344, 12'h7C0};
    logic [31:0] st, ie, e_pc, e_rd;
    logic act, irq, e_trap, e_commit;
    int kind;
    do_reset();
    m_reset();
    for (int n = 0; n < 600; n++) begin
      wb_valid_i = $urandom_range(3) != 0;
      wb_pc_i = $urandom;
      wb_exc_i = $urandom_range(7) == 0;
      wb_exc_cause_i = 4'($urandom);
      wb_exc_tval_i = $urandom;
      wb_mret_i = $urandom_range(5) == 0;
      csr_we_i = 1'($urandom_range(1));
      csr_addr_i = addrs[$urandom_range(7)];
      csr_wdata_i = $urandom_range(3) == 0 ? 32'h88 : $urandom;
      irq_timer_i = 1'($urandom_range(1));
      st = m_read(12'h300);
      ie = m_read(12'h304);
      irq = IRQ_EN && st[3] && ie[7] && m_mtip;
      act = wb_valid_i && !m_drain;
      kind = !act ? 0 : wb_exc_i ? 1 : irq ? 2 : wb_mret_i ? 3 : 4;
      e_trap = kind inside {1, 2, 3};
      e_pc = kind inside {1, 2} ? (m_csr[12'h305] & ~32'h3) : kind == 3 ? m_csr[12'h341] : 32'h0;
      e_commit = kind >= 3;
      e_rd = m_read(csr_addr_i);
      #1;
      n_chk++; if (wb_trap_o !== e_trap) begin n_fail++; $display("FAIL rnd_trap[%0d] got %h want %h", n, wb_trap_o, e_trap); end
      n_chk++; if (wb_trap_handle_pc_o !== e_pc) begin n_fail++; $display("FAIL rnd_pc[%0d] got %h want %h", n, wb_trap_handle_pc_o, e_pc); end
      n_chk++; if (wb_commit_o !== e_commit) begin n_fail++; $display("FAIL rnd_commit[%0d] got %h want %h", n, wb_commit_o, e_commit); end
      n_chk++; if (csr_rdata_o !== e_rd) begin n_fail++; $display("FAIL rnd_rdata[%0d] addr %h got %h want %h", n, csr_addr_i, csr_rdata_o, e_rd); end
      if (kind == 1 || kind == 2) begin
        m_csr[12'h341] = wb_pc_i;
        m_csr[12'h342] = kind == 2 ? 32'h8000_0007 : {28'b0, wb_exc_cause_i};
        m_csr[12'h343] = kind == 2 ? 32'h0 : wb_exc_tval_i;
        m_csr[12'h300] = st[3] ? 32'h80 : 32'h0;
      end else if (kind == 3) begin
        m_csr[12'h300] = st[7] ? 32'h88 : 32'h80;
      end else if (kind == 4 && csr_we_i && m_wmask.exists(csr_addr_i)) begin
        m_csr[csr_addr_i] = csr_wdata_i & m_wmask[csr_addr_i];
      end
      m_mtip = IRQ_EN && irq_timer_i;
      m_drain = e_trap;
      tick();
    end
    idle();
  endtask

  initial begin
    idle();
    irq_timer_i = 0;
    test_reset();
    test_exception();
    test_mret();
    test_drain();
    test_interrupt();
    test_csr_map();
    test_reset_in_drain();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
